// File: rtl/bist_pkg.sv
// Shared BIST definitions: MISR width, the x^7+x^6+1 tap mask used by both the
// TPG and the MISR, the controller state encoding and the MISR step function.
package bist_pkg;

    localparam int MISR_W = 7;

    // Bits of the register XORed into the top feedback bit (x^7 + x^6 + 1).
    localparam logic [MISR_W-1:0] POLY_TAPS = 7'b110_0000;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        INIT    = 3'd1,
        SHIFT   = 3'd2,
        CAPTURE = 3'd3,
        FLUSH   = 3'd4,
        DONE    = 3'd5
    } bist_state_t;

    function automatic logic [MISR_W-1:0] misr_step(input logic [MISR_W-1:0] q,
                                                    input logic [MISR_W-1:0] d);
        return {^(q & POLY_TAPS), q[MISR_W-3:0], q[MISR_W-1]} ^ d;
    endfunction

endpackage

// File: rtl/misr7.sv
// 7-bit parallel-input MISR. Synchronous clear wins over enable; the next-state
// value is exported so the controller can judge the final signature on entry to DONE.
module misr7
    import bist_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              en_i,
    input  logic [MISR_W-1:0] d_i,
    output logic [MISR_W-1:0] q_o,
    output logic [MISR_W-1:0] q_next_o
);

    logic [MISR_W-1:0] q_q;
    logic [MISR_W-1:0] q_d;

    // Next-state selection: clear, compact or hold.
    always_comb begin
        q_d = q_q;
        if (clr_i) begin
            q_d = {MISR_W{1'b0}};
        end else if (en_i) begin
            q_d = misr_step(q_q, d_i);
        end else begin
            q_d = q_q;
        end
    end

    // Signature register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            q_q <= {MISR_W{1'b0}};
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o      = q_q;
    assign q_next_o = q_d;

endmodule

// File: rtl/bist_misr_ctrl.sv
// BIST sequencer for the s9234 scan wrapper: drives shift/capture, compacts the
// seven scan-out chains into a MISR and reports pass/fail against GOLDEN.
module bist_misr_ctrl
    import bist_pkg::*;
#(
    parameter int                CHAIN_LEN    = 33,
    parameter int                NUM_PATTERNS = 100,
    parameter logic [MISR_W-1:0] GOLDEN       = 7'h00
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic [MISR_W-1:0] so_chain,
    output logic              scan_en,
    output logic              bist_en,
    output logic              tpg_reset,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature
);

    localparam int SH_W  = $clog2(CHAIN_LEN + 1);
    localparam int PAT_W = $clog2(NUM_PATTERNS + 1);

    bist_state_t        state_q;
    logic [SH_W-1:0]    sh_cnt_q;
    logic [PAT_W-1:0]   pat_cnt_q;
    logic               scan_en_q;
    logic               bist_en_q;
    logic               tpg_reset_q;
    logic               busy_q;
    logic               done_q;
    logic               pass_q;
    logic               comp_q;
    logic               sh_last_s;
    logic               pat_last_s;
    logic               misr_clr_s;
    logic [MISR_W-1:0]  misr_q_s;
    logic [MISR_W-1:0]  misr_next_s;

    assign sh_last_s  = (sh_cnt_q == SH_W'(CHAIN_LEN - 1));
    assign pat_last_s = (pat_cnt_q == PAT_W'(NUM_PATTERNS - 1));
    assign misr_clr_s = (state_q == INIT);

    // Outputs trail the state by one edge so each pin is a flop; comp_q lines the
    // MISR up with the cycles where the scan_en pin actually shifts the CUT.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            sh_cnt_q    <= {SH_W{1'b0}};
            pat_cnt_q   <= {PAT_W{1'b0}};
            scan_en_q   <= 1'b0;
            bist_en_q   <= 1'b0;
            tpg_reset_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            comp_q      <= 1'b0;
        end else begin
            scan_en_q   <= (state_q == INIT) || (state_q == SHIFT) || (state_q == FLUSH);
            bist_en_q   <= (state_q == INIT) || (state_q == SHIFT) ||
                           (state_q == CAPTURE) || (state_q == FLUSH);
            busy_q      <= (state_q == INIT) || (state_q == SHIFT) ||
                           (state_q == CAPTURE) || (state_q == FLUSH);
            tpg_reset_q <= (state_q == INIT);
            done_q      <= (state_q == DONE);
            // The first load unloads uninitialised flops, so it is never compacted.
            comp_q      <= ((state_q == SHIFT) && (pat_cnt_q != {PAT_W{1'b0}})) ||
                           (state_q == FLUSH);
            case (state_q)
                IDLE: begin
                    if (start) begin
                        state_q <= INIT;
                    end
                end
                INIT: begin
                    state_q   <= SHIFT;
                    sh_cnt_q  <= {SH_W{1'b0}};
                    pat_cnt_q <= {PAT_W{1'b0}};
                    pass_q    <= 1'b0;
                end
                SHIFT: begin
                    if (sh_last_s) begin
                        state_q  <= CAPTURE;
                        sh_cnt_q <= {SH_W{1'b0}};
                    end else begin
                        sh_cnt_q <= sh_cnt_q + SH_W'(1);
                    end
                end
                CAPTURE: begin
                    pat_cnt_q <= pat_cnt_q + PAT_W'(1);
                    state_q   <= pat_last_s ? FLUSH : SHIFT;
                end
                FLUSH: begin
                    if (sh_last_s) begin
                        state_q  <= DONE;
                        sh_cnt_q <= {SH_W{1'b0}};
                    end else begin
                        sh_cnt_q <= sh_cnt_q + SH_W'(1);
                    end
                end
                DONE: begin
                    if (!done_q) begin
                        pass_q <= (misr_next_s == GOLDEN);
                    end
                    if (start) begin
                        state_q <= INIT;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    misr7 u_misr (
        .clk_i    (CK),
        .rst_i    (reset),
        .clr_i    (misr_clr_s),
        .en_i     (comp_q),
        .d_i      (so_chain),
        .q_o      (misr_q_s),
        .q_next_o (misr_next_s)
    );

    assign scan_en   = scan_en_q;
    assign bist_en   = bist_en_q;
    assign tpg_reset = tpg_reset_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign pass      = pass_q;
    assign signature = misr_q_s;

endmodule

// File: tb/tb_bist_misr_ctrl.sv
// Directed bench for bist_misr_ctrl (CHAIN_LEN=4, NUM_PATTERNS=2) plus a misr7 step check.
module tb_bist_misr_ctrl;

    localparam int          CL       = 4;
    localparam int          NP       = 2;
    localparam logic [6:0]  GOLD     = 7'h00;
    localparam int          BUSY_CYC = 1 + NP * (CL + 1) + CL;

    logic       CK = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [6:0] so_chain = 7'h00;
    logic       scan_en, bist_en, tpg_reset, busy, done, pass;
    logic [6:0] signature;

    logic       m_clr = 1'b0;
    logic       m_en = 1'b0;
    logic [6:0] m_d = 7'h00;
    logic [6:0] m_q, m_next;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [6:0] sig;
        logic       pas;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    bist_misr_ctrl #(.CHAIN_LEN(CL), .NUM_PATTERNS(NP), .GOLDEN(GOLD)) dut (
        .CK(CK), .reset(reset), .start(start), .so_chain(so_chain),
        .scan_en(scan_en), .bist_en(bist_en), .tpg_reset(tpg_reset),
        .busy(busy), .done(done), .pass(pass), .signature(signature)
    );

    misr7 u_m (
        .clk_i(CK), .rst_i(reset), .clr_i(m_clr), .en_i(m_en),
        .d_i(m_d), .q_o(m_q), .q_next_o(m_next)
    );

    always #5 CK = ~CK;

    function automatic logic [6:0] ref_step(input logic [6:0] q, input logic [6:0] d);
        return {q[6] ^ q[5], q[4:0], q[6]} ^ d;
    endfunction

    // Compactions happen in every SHIFT after the first plus the FLUSH.
    function automatic logic [6:0] ref_sig(input logic [6:0] so);
        logic [6:0] q = 7'h00;
        for (int n = 0; n < CL * NP; n++) q = ref_step(q, so);
        return q;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CK);
        #1;
    endtask

    task automatic push_exp(input logic [6:0] so);
        exp_t e;
        e.sig = ref_sig(so);
        e.pas = (e.sig == GOLD);
        e.cyc = BUSY_CYC;
        sb.push_back(e);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_scan_en"},   scan_en,   1'b0);
        chk({tag, "_bist_en"},   bist_en,   1'b0);
        chk({tag, "_tpg_reset"}, tpg_reset, 1'b0);
        chk({tag, "_busy"},      busy,      1'b0);
        chk({tag, "_done"},      done,      1'b0);
        chk({tag, "_pass"},      pass,      1'b0);
        chk({tag, "_sig"},       signature, 7'h00);
    endtask

    // Runs to done (bounded), optionally re-pulsing start at edge restart_at, then scores.
    task automatic finish_run(input string tag, input int restart_at);
        int   cyc = 0;
        logic seen = 1'b0;
        exp_t e;
        for (int ed = 1; ed <= 200; ed++) begin
            start = (ed == restart_at);
            tick();
            if (ed == 1) begin
                chk({tag, "_done_drop"}, done, 1'b0);
                chk({tag, "_busy_rise"}, busy, 1'b1);
            end
            if (busy) cyc++;
            if (done) begin
                seen = 1'b1;
                break;
            end
        end
        start = 1'b0;
        chk({tag, "_done_seen"}, seen, 1'b1);
        chk({tag, "_sb_size"}, sb.size(), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_sig"},  signature, e.sig);
            chk({tag, "_pass"}, pass,      e.pas);
            chk({tag, "_cyc"},  cyc,       e.cyc);
        end
    endtask

    initial begin
        exp_t e;
        // Reset state
        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;

        // misr7 step checks
        m_clr = 1'b1; tick();
        m_clr = 1'b0; m_en = 1'b1; m_d = 7'h01; tick();
        chk("misr_00_01", m_q, 7'h01);
        m_en = 1'b0; m_clr = 1'b1; tick();
        m_clr = 1'b0; m_en = 1'b1; m_d = 7'h40; tick();
        chk("misr_load40", m_q, 7'h40);
        m_d = 7'h00; tick();
        chk("misr_40_00", m_q, 7'h41);
        m_en = 1'b0;

        // Latency with all-zero chains
        so_chain = 7'h00;
        push_exp(7'h00);
        pulse_start();
        for (int ed = 1; ed <= 16; ed++) begin
            tick();
            chk($sformatf("lat_busy_e%0d", ed), busy, (ed <= 15));
            chk($sformatf("lat_bist_e%0d", ed), bist_en, (ed <= 15));
            chk($sformatf("lat_scan_e%0d", ed), scan_en, (ed <= 15) && (ed != 6) && (ed != 11));
            chk($sformatf("lat_tpgr_e%0d", ed), tpg_reset, (ed == 1));
            chk($sformatf("lat_done_e%0d", ed), done, (ed == 16));
        end
        e = sb.pop_front();
        chk("zero_sig",  signature, e.sig);
        chk("zero_pass", pass,      e.pas);

        // Constant 7'h01 on the chains, started from DONE
        so_chain = 7'h01;
        push_exp(7'h01);
        pulse_start();
        finish_run("so01", -1);

        // start re-pulsed while busy is ignored
        push_exp(7'h01);
        pulse_start();
        finish_run("restart", 5);

        // Reset during the second SHIFT, then a clean run
        push_exp(7'h01);
        pulse_start();
        for (int ed = 1; ed <= 8; ed++) tick();
        chk("mid_sig_e8", signature, ref_step(7'h00, 7'h01));
        #2 reset = 1'b1;
        #1;
        check_reset_vals("midrst");
        sb.delete();
        tick();
        reset = 1'b0;
        tick();
        push_exp(7'h01);
        pulse_start();
        finish_run("after_rst", -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bist_misr_ctrl.md
# bist_misr_ctrl

Downstream BIST stage for the s9234 scan wrapper. It sequences scan shift and capture by driving `scan_en`, `bist_en` and the TPG reset, and compacts the seven scan-out chains into a 7-bit MISR. It compares the final signature against a golden value and reports pass/fail. It sits between the `SO_chain1..7` outputs of `s9234_scan` and the tester-visible BIST status pins.

## Interface
Parameters:
- `CHAIN_LEN`, default 33: flops per scan chain, which is the number of shift cycles per pattern.
- `NUM_PATTERNS`, default 100: number of capture cycles per BIST run.
- `GOLDEN`, default 7'h00: expected final signature.

Ports (clock and reset first):
- `CK`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high; returns the block to IDLE.
- `start`  in  1: starts a run. Sampled only in IDLE or DONE.
- `so_chain`  in  7: bit i is `SO_chain(i+1)`.
- `scan_en`  out  1: to CUT; 1 means shift, 0 means capture.
- `bist_en`  out  1: to the TPG input muxes; 1 during a run.
- `tpg_reset`  out  1: synchronous reset for `lfsr_tpg`.
- `busy`  out  1: run in progress.
- `done`  out  1: run complete; held until the next `start` or `reset`.
- `pass`  out  1: `signature == GOLDEN`; valid only while `done` is high.
- `signature`  out  7: current MISR contents.

## Operation
- States and transitions:
  - IDLE → INIT when `start` is high.
  - INIT → SHIFT.
  - SHIFT → CAPTURE after `CHAIN_LEN` cycles.
  - CAPTURE → SHIFT if patterns remaining > 0.
  - CAPTURE → FLUSH after the `NUM_PATTERNS`-th capture.
  - FLUSH → DONE after `CHAIN_LEN` cycles.
  - DONE → INIT when `start` is high.
- INIT, one cycle:
  - `tpg_reset`=1, `scan_en`=1, `bist_en`=1.
  - MISR cleared to 0, shift counter cleared, pattern counter cleared.
- SHIFT:
  - `scan_en`=1, `bist_en`=1.
  - Shift counter runs 0..`CHAIN_LEN`-1.
  - MISR compacts only when pattern counter ≥ 1. The first load unloads uninitialised flops, which must not be compacted.
- CAPTURE, one cycle:
  - `scan_en`=0, `bist_en`=1.
  - Pattern counter increments; MISR holds.
- FLUSH:
  - `scan_en`=1; the MISR compacts every cycle, unloading the last response.
  - `bist_en` stays 1 so the TPG keeps running; its values are don't-care.
- DONE:
  - `scan_en`=0, `bist_en`=0, `busy`=0, `done`=1.
  - `pass` is registered on DONE entry; MISR holds.
- MISR update when compacting: `q_next = {q[6]^q[5], q[4:0], q[6]} ^ so_chain`. This is the same polynomial as the TPG, x^7+x^6+1.
- Counter widths: `$clog2(CHAIN_LEN+1)` and `$clog2(NUM_PATTERNS+1)`. Counters never wrap; terminal-count compares drive the transitions.
- `start` outside IDLE/DONE is ignored; no queuing.

## Timing
- Reset values of all outputs:
  - `scan_en`=0, `bist_en`=0, `tpg_reset`=0.
  - `busy`=0, `done`=0, `pass`=0, `signature`=7'h00.
- `reset` asserted mid-run: immediate return to IDLE with the values above; the partial signature is discarded.
- All outputs are registered. `start` sampled at edge k gives `busy`=1 and `tpg_reset`=1 from edge k+1.
- `busy` stays high for exactly 1 + `NUM_PATTERNS`×(`CHAIN_LEN`+1) + `CHAIN_LEN` cycles. `done` rises on the edge where `busy` falls.
- `so_chain` is sampled on the same edge at which the CUT shifts, so the MISR consumes the value that was present during the shift cycle.

## Structure
- Shared package `bist_pkg` holds:
  - `MISR_W` = 7;
  - the tap constant for x^7+x^6+1, shared with `lfsr_tpg`;
  - the state enum (IDLE, INIT, SHIFT, CAPTURE, FLUSH, DONE).
- One sub-module, `misr7`:
  - 7-bit parallel-input MISR with synchronous `clr` and `en`, plus asynchronous `reset`;
  - instantiated once.
- The FSM and both counters live in `bist_misr_ctrl`.

## Test plan
- MISR step, via `misr7` unit test:
  - q=7'h00, so=7'h01 → 7'h01;
  - q=7'h40, so=7'h00 → 7'h41.
- Latency (`CHAIN_LEN`=4, `NUM_PATTERNS`=2, `start` pulsed at edge 0):
  - `busy` high for edges 1–15;
  - `scan_en`=0 exactly at edges 6 and 11;
  - `done`=1 from edge 16.
- All-zero `so_chain`, `GOLDEN`=0 → `signature`=7'h00, `pass`=1.
- `so_chain`=7'h01 held for the whole run, parameters as in the latency test → the MISR steps only in pattern-2 SHIFT and FLUSH, 8 compaction cycles. `signature` must match the reference model, and `pass`=0 when `GOLDEN`=0.
- `reset` asserted during the second SHIFT:
  - all outputs return to their reset values asynchronously;
  - a new `start` gives the same final signature as a clean run.
- `start` re-pulsed while `busy`=1 → ignored; cycle count unchanged. `start` in DONE → `done` drops and a new run begins.
